// File: rtl/addr_map_rule_pkg.sv
// Address map rule type: half-open range [start_addr, end_addr) mapped to idx.
package addr_map_rule_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

endpackage

// File: rtl/cei_mochila_pkg.sv
// Shared CEI bus constants: target-id sizing, error-target encoding and the
// default read data returned by the internal error responder.
package cei_mochila_pkg;

    // Slave ids 0..nslave-1 plus one extra code for the error responder.
    function automatic int tgt_id_w(input int nslave);
        return $clog2(nslave + 1);
    endfunction

    function automatic int err_id(input int nslave);
        return nslave;
    endfunction

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;

endpackage

// File: rtl/cei_obi_addr_demux_if.sv
// OBI bus bundle seen by the address demux: one upstream master, NSLAVE slaves.
interface cei_obi_addr_demux_if #(
    parameter int NSLAVE = 6
);
    // Handshake: an address phase completes in a cycle where req && gnt; a
    // response is a single cycle with rvalid high, no back-pressure on it.
    logic                   m_req_i;
    logic                   m_gnt_o;
    logic [31:0]            m_addr_i;
    logic [31:0]            m_wdata_i;
    logic                   m_we_i;
    logic [3:0]             m_be_i;
    logic                   m_rvalid_o;
    logic [31:0]            m_rdata_o;
    logic                   m_err_o;

    logic [NSLAVE-1:0]      s_req_o;
    logic [NSLAVE-1:0]      s_gnt_i;
    logic [NSLAVE-1:0]      s_rvalid_i;
    logic [31:0]            s_addr_o;
    logic [31:0]            s_wdata_o;
    logic                   s_we_o;
    logic [3:0]             s_be_o;
    logic [NSLAVE-1:0][31:0] s_rdata_i;

    modport slave (
        input  m_req_i, m_addr_i, m_wdata_i, m_we_i, m_be_i,
        input  s_gnt_i, s_rvalid_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
        output s_req_o, s_addr_o, s_wdata_o, s_we_o, s_be_o
    );

    modport master (
        output m_req_i, m_addr_i, m_wdata_i, m_we_i, m_be_i,
        output s_gnt_i, s_rvalid_i, s_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
        input  s_req_o, s_addr_o, s_wdata_o, s_we_o, s_be_o
    );

endinterface

// File: rtl/cei_id_fifo.sv
// Small synchronous FIFO of target ids; exposes head, last pushed entry and count.
module cei_id_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [WIDTH-1:0]         last_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]                 count_q, count_d;
    logic [WIDTH-1:0]            last_q, last_d;
    logic                        do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign last_o  = last_q;
    assign count_o = count_q;

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        last_d  = last_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = wptr_q + PW'(1);
            last_d        = data_i;
        end
        if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            last_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cei_obi_addr_demux.sv
// One-master to NSLAVE-slave OBI address demux with an in-order response
// table and an internal error responder for unmapped addresses.
module cei_obi_addr_demux
    import cei_mochila_pkg::*;
    import addr_map_rule_pkg::*;
#(
    parameter int          NRULES          = 6,
    parameter int          NSLAVE          = 6,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] ERR_RDATA       = ERR_RDATA_DEFAULT
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  addr_map_rule_t [NRULES-1:0]       addr_rules_i,
    cei_obi_addr_demux_if.slave               bus,
    output logic                              spurious_rsp_o,
    output logic [$clog2(MAX_OUTSTANDING):0]  dbg_count_o
);
    localparam int             IDW    = tgt_id_w(NSLAVE);
    localparam logic [IDW-1:0] ERR_ID = IDW'(err_id(NSLAVE));

    // Lowest-index matching rule wins; out-of-range slave idx maps to ERR.
    function automatic logic [IDW-1:0] decode(input logic [31:0] addr,
                                              input addr_map_rule_t [NRULES-1:0] rules);
        logic [IDW-1:0] t;
        logic           found;
        t     = ERR_ID;
        found = 1'b0;
        for (int r = 0; r < NRULES; r++) begin
            if (!found && (addr >= rules[r].start_addr) && (addr < rules[r].end_addr)) begin
                found = 1'b1;
                t     = (rules[r].idx < 32'(NSLAVE)) ? IDW'(rules[r].idx) : ERR_ID;
            end
        end
        return t;
    endfunction

    logic [IDW-1:0]    tgt, fifo_head, fifo_last;
    logic              tgt_is_err, head_is_err, issue_ok, sel_gnt, push, pop;
    logic              fifo_full, fifo_empty;
    logic [NSLAVE-1:0] s_req, accept_mask;
    logic              rvalid, rerr;
    logic [31:0]       rdata;
    logic              err_pending_q, err_pending_d;

    assign bus.s_addr_o  = bus.m_addr_i;
    assign bus.s_wdata_o = bus.m_wdata_i;
    assign bus.s_we_o    = bus.m_we_i;
    assign bus.s_be_o    = bus.m_be_i;

    // Only one target may be outstanding at a time, so responses never reorder.
    always_comb begin
        tgt        = decode(bus.m_addr_i, addr_rules_i);
        tgt_is_err = (tgt == ERR_ID);
        issue_ok   = !fifo_full && (fifo_empty || (tgt == fifo_last));
        sel_gnt    = 1'b0;
        s_req      = '0;
        for (int s = 0; s < NSLAVE; s++) begin
            if (tgt == IDW'(s)) begin
                sel_gnt  = bus.s_gnt_i[s];
                s_req[s] = bus.m_req_i && issue_ok;
            end
        end
        push = bus.m_req_i && issue_ok && (tgt_is_err || sel_gnt);
    end

    always_comb begin
        head_is_err = (fifo_head == ERR_ID);
        rvalid      = 1'b0;
        rerr        = 1'b0;
        rdata       = '0;
        accept_mask = '0;
        if (!fifo_empty) begin
            if (head_is_err) begin
                rvalid = err_pending_q;
                rerr   = err_pending_q;
                rdata  = err_pending_q ? ERR_RDATA : '0;
            end else begin
                for (int s = 0; s < NSLAVE; s++) begin
                    if (fifo_head == IDW'(s)) begin
                        accept_mask[s] = 1'b1;
                        rvalid         = bus.s_rvalid_i[s];
                        rdata          = bus.s_rvalid_i[s] ? bus.s_rdata_i[s] : '0;
                    end
                end
            end
        end
        pop           = rvalid;
        err_pending_d = (err_pending_q && !(pop && head_is_err)) || (push && tgt_is_err);
    end

    assign bus.s_req_o    = s_req;
    assign bus.m_gnt_o    = push;
    assign bus.m_rvalid_o = rvalid;
    assign bus.m_rdata_o  = rdata;
    assign bus.m_err_o    = rerr;
    assign spurious_rsp_o = |(bus.s_rvalid_i & ~accept_mask);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_pending_q <= 1'b0;
        end else begin
            err_pending_q <= err_pending_d;
        end
    end

    cei_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (tgt),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .last_o  (fifo_last),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (dbg_count_o)
    );

endmodule

// File: tb/tb_cei_obi_addr_demux.sv
// Directed bench for cei_obi_addr_demux: expected responses are queued at
// issue time and a negedge monitor compares them as m_rvalid_o appears.
module tb_cei_obi_addr_demux;
    import cei_mochila_pkg::*;
    import addr_map_rule_pkg::*;

    localparam int NRULES = 6;
    localparam int NSLAVE = 6;
    localparam logic [32:0] ERR_EXP = {1'b1, 32'hBADACCE5};

    logic clk;
    logic rst;
    logic spurious;
    logic [2:0] dbg_count;
    addr_map_rule_t [NRULES-1:0] rules;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    cei_obi_addr_demux_if #(.NSLAVE(NSLAVE)) bus ();

    cei_obi_addr_demux #(
        .NRULES(NRULES), .NSLAVE(NSLAVE), .MAX_OUTSTANDING(4), .ERR_RDATA(32'hBADACCE5)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .addr_rules_i   (rules),
        .bus            (bus),
        .spurious_rsp_o (spurious),
        .dbg_count_o    (dbg_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic req(input logic [31:0] a);
        bus.m_req_i   = 1'b1;
        bus.m_addr_i  = a;
        bus.m_wdata_i = ~a;
        bus.m_we_i    = 1'b0;
        bus.m_be_i    = 4'hF;
    endtask

    task automatic no_req();
        bus.m_req_i = 1'b0;
    endtask

    task automatic rsp(input int s, input logic [31:0] d);
        bus.s_rvalid_i    = '0;
        bus.s_rvalid_i[s] = 1'b1;
        bus.s_rdata_i[s]  = d;
    endtask

    task automatic no_rsp();
        bus.s_rvalid_i = '0;
    endtask

    task automatic slave_read(input string name, input logic [31:0] a, input int s,
                              input logic [5:0] sreq_exp, input logic [31:0] d);
        exp_q.push_back({1'b0, d});
        req(a);
        sample();
        check({name, "_sreq"}, 64'(bus.s_req_o), 64'(sreq_exp));
        check({name, "_gnt"}, 64'(bus.m_gnt_o), 64'd1);
        cyc();
        no_req();
        rsp(s, d);
        cyc();
        no_rsp();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && bus.m_rvalid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got err=%0b rdata=%08h, none expected",
                         bus.m_err_o, bus.m_rdata_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.m_err_o, bus.m_rdata_o} !== mon_exp) begin
                    errors++;
                    $display("FAIL rsp_data: got err=%0b rdata=%08h expected err=%0b rdata=%08h",
                             bus.m_err_o, bus.m_rdata_o, mon_exp[32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.m_req_i    = 1'b0;
        bus.m_addr_i   = '0;
        bus.m_wdata_i  = '0;
        bus.m_we_i     = 1'b0;
        bus.m_be_i     = '0;
        bus.s_gnt_i    = '0;
        bus.s_rvalid_i = '0;
        bus.s_rdata_i  = '0;
        for (int i = 0; i < NRULES; i++) rules[i] = '0;
        rules[0] = '{idx: 32'd1, start_addr: 32'h1000, end_addr: 32'h2000};
        rules[1] = '{idx: 32'd2, start_addr: 32'h1800, end_addr: 32'h3000};
        rules[2] = '{idx: 32'(NSLAVE + 2), start_addr: 32'h4000, end_addr: 32'h5000};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        sample();
        check("rst_gnt", 64'(bus.m_gnt_o), 64'd0);
        check("rst_rvalid", 64'(bus.m_rvalid_o), 64'd0);
        check("rst_err", 64'(bus.m_err_o), 64'd0);
        check("rst_rdata", 64'(bus.m_rdata_o), 64'd0);
        check("rst_spurious", 64'(spurious), 64'd0);
        check("rst_sreq", 64'(bus.s_req_o), 64'd0);
        check("rst_count", 64'(dbg_count), 64'd0);
        cyc();

        // priority and end-exclusive decode
        bus.s_gnt_i = 6'b000110;
        slave_read("prio_1800", 32'h1800, 1, 6'b000010, 32'hA1A1_0001);
        slave_read("endx_2000", 32'h2000, 2, 6'b000100, 32'hA2A2_0002);

        // unmapped address: error one cycle after grant
        req(32'h3000);
        sample();
        check("err_sreq", 64'(bus.s_req_o), 64'd0);
        check("err_gnt", 64'(bus.m_gnt_o), 64'd1);
        check("err_rvalid_same", 64'(bus.m_rvalid_o), 64'd0);
        exp_q.push_back(ERR_EXP);
        cyc();
        no_req();
        sample();
        check("err_lat_rvalid", 64'(bus.m_rvalid_o), 64'd1);
        cyc();
        sample();
        check("err_after_rvalid", 64'(bus.m_rvalid_o), 64'd0);
        cyc();

        // fill the table, fifth request waits for a pop then a free slot
        bus.s_gnt_i = 6'b000010;
        for (int k = 0; k < 4; k++) begin
            req(32'h1000 + 32'(4 * k));
            exp_q.push_back({1'b0, 32'hB000_0000 + 32'(k)});
            sample();
            check("fill_gnt", 64'(bus.m_gnt_o), 64'd1);
            cyc();
        end
        req(32'h1010);
        sample();
        check("full_gnt", 64'(bus.m_gnt_o), 64'd0);
        check("full_sreq", 64'(bus.s_req_o), 64'd0);
        check("full_count", 64'(dbg_count), 64'd4);
        cyc();
        rsp(1, 32'hB000_0000);
        sample();
        check("full_pop_gnt", 64'(bus.m_gnt_o), 64'd0);
        cyc();
        rsp(1, 32'hB000_0001);
        exp_q.push_back({1'b0, 32'hB000_0004});
        sample();
        check("freed_gnt", 64'(bus.m_gnt_o), 64'd1);
        cyc();
        no_req();
        rsp(1, 32'hB000_0002);
        sample();
        check("freed_count", 64'(dbg_count), 64'd3);
        cyc();
        rsp(1, 32'hB000_0003);
        cyc();
        rsp(1, 32'hB000_0004);
        cyc();
        no_rsp();
        sample();
        check("drain_count", 64'(dbg_count), 64'd0);
        cyc();

        // different target waits until the table empties
        bus.s_gnt_i = 6'b000110;
        req(32'h1000);
        exp_q.push_back({1'b0, 32'hC1C1_0001});
        sample();
        check("xt_first_gnt", 64'(bus.m_gnt_o), 64'd1);
        cyc();
        req(32'h2000);
        sample();
        check("xt_stall_sreq", 64'(bus.s_req_o), 64'd0);
        check("xt_stall_gnt", 64'(bus.m_gnt_o), 64'd0);
        cyc();
        rsp(1, 32'hC1C1_0001);
        sample();
        check("xt_pop_sreq", 64'(bus.s_req_o), 64'd0);
        cyc();
        no_rsp();
        exp_q.push_back({1'b0, 32'hC2C2_0002});
        sample();
        check("xt_empty_sreq", 64'(bus.s_req_o), 64'd4);
        check("xt_empty_gnt", 64'(bus.m_gnt_o), 64'd1);
        cyc();
        no_req();
        rsp(2, 32'hC2C2_0002);
        cyc();
        no_rsp();

        // idx beyond NSLAVE acts as ERR, back-to-back error responses
        for (int k = 0; k < 3; k++) begin
            req(32'h4000 + 32'(4 * k));
            exp_q.push_back(ERR_EXP);
            sample();
            check("err3_gnt", 64'(bus.m_gnt_o), 64'd1);
            check("err3_sreq", 64'(bus.s_req_o), 64'd0);
            if (k > 0) check("err3_rvalid", 64'(bus.m_rvalid_o), 64'd1);
            cyc();
        end
        no_req();
        sample();
        check("err3_last_rvalid", 64'(bus.m_rvalid_o), 64'd1);
        cyc();
        sample();
        check("err3_idle_rvalid", 64'(bus.m_rvalid_o), 64'd0);
        cyc();

        // simultaneous push and pop at count 2
        bus.s_gnt_i = 6'b000010;
        req(32'h1000);
        exp_q.push_back({1'b0, 32'hD000_0000});
        cyc();
        req(32'h1004);
        exp_q.push_back({1'b0, 32'hD000_0001});
        cyc();
        req(32'h1008);
        exp_q.push_back({1'b0, 32'hD000_0002});
        rsp(1, 32'hD000_0000);
        sample();
        check("pp_count_before", 64'(dbg_count), 64'd2);
        check("pp_gnt", 64'(bus.m_gnt_o), 64'd1);
        cyc();
        no_req();
        rsp(1, 32'hD000_0001);
        sample();
        check("pp_count_after", 64'(dbg_count), 64'd2);
        cyc();
        rsp(1, 32'hD000_0002);
        cyc();
        no_rsp();

        // reset with two outstanding: later response is spurious
        req(32'h1000);
        cyc();
        req(32'h1004);
        cyc();
        no_req();
        sample();
        check("mr_count_before", 64'(dbg_count), 64'd2);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        sample();
        check("mr_count_after", 64'(dbg_count), 64'd0);
        cyc();
        rsp(1, 32'hDEAD_BEEF);
        sample();
        check("mr_rvalid", 64'(bus.m_rvalid_o), 64'd0);
        check("mr_rdata", 64'(bus.m_rdata_o), 64'd0);
        check("mr_spurious", 64'(spurious), 64'd1);
        cyc();
        no_rsp();
        sample();
        check("mr_spurious_end", 64'(spurious), 64'd0);
        check("mr_count_end", 64'(dbg_count), 64'd0);
        cyc();

        // final report
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses still expected, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cei_obi_addr_demux.md
# cei_obi_addr_demux

Parametrised one-master-to-N-slave OBI address demultiplexer for the CEI system bus. It replaces static per-master decode logic. Each request is decoded against a rule table supplied as a port: rules are half-open address ranges, and the lowest matching rule index wins. The request is forwarded to the selected slave, and an in-order table of outstanding transactions routes each response back to the master. Unmapped addresses are absorbed by an internal error responder.

## Interface
Parameters:
- NRULES, 6, number of address rules.
- NSLAVE, 6, number of slave ports.
- MAX_OUTSTANDING, 4, depth of the outstanding-transaction FIFO (power of two, ≥2).
- ERR_RDATA, 32'hBADACCE5, rdata returned on error responses.

Ports:
- Clock and reset are decided: one clock, `clk_i`, and a synchronous, active-high reset, `rst_i`.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- addr_rules_i  in  NRULES×addr_map_rule_t  rule table (idx, start_addr, end_addr); quasi-static.
- m_req_i / m_gnt_o  in/out  1  master request / grant.
- m_addr_i, m_wdata_i  in  32 each  address, write data.
- m_we_i  in  1  write enable.
- m_be_i  in  4  byte enables.
- m_rvalid_o  out  1  response valid.
- m_rdata_o  out  32  response data.
- m_err_o  out  1  error response flag.
- s_req_o, s_gnt_i, s_rvalid_i  out/in/in  NSLAVE  per-slave handshake.
- s_addr_o, s_wdata_o, s_we_o, s_be_o  out  broadcast copies of the master fields.
- s_rdata_i  in  NSLAVE×32  per-slave read data.
- spurious_rsp_o  out  1  one-cycle pulse: s_rvalid_i seen with no matching outstanding entry.

## Operation
- Decode is combinational:
  - hit[r] = (addr ≥ start_addr[r]) && (addr < end_addr[r]), compared as unsigned 32-bit.
  - The selection is the lowest r with a hit. The target is idx[r].
  - With no hit, or with idx ≥ NSLAVE, the target is ERR (encoded as NSLAVE).
- Target id width is $clog2(NSLAVE+1).
- Issue conditions. A request may issue only when:
  - the FIFO is not full; and
  - the FIFO is empty, or the target equals the id of the last pushed entry (same-target rule; this prevents response reordering).
- Otherwise the request stalls: s_req_o is all 0 and m_gnt_o is 0.
- Slave target: s_req_o[tgt] = m_req_i && issue_ok, and m_gnt_o = s_gnt_i[tgt]. On each handshake (req && gnt), push tgt.
- ERR target: m_gnt_o = 1 when issue_ok. The handshake pushes ERR and sets the registered err_pending.
- Response path: the FIFO head id selects the source.
  - Slave head: m_rvalid_o = s_rvalid_i[head], m_rdata_o = s_rdata_i[head], m_err_o = 0. Pop on valid.
  - ERR head: m_rvalid_o = err_pending, m_rdata_o = ERR_RDATA, m_err_o = 1. Pop on valid.
- Any s_rvalid_i bit that is asserted while the FIFO is empty, or that does not belong to the head id, is dropped and pulses spurious_rsp_o.
- Push and pop in the same cycle are legal at any occupancy below full; the count is unchanged.

## Timing
- Reset values:
  - FIFO empty, count 0, err_pending 0.
  - m_gnt_o 0, m_rvalid_o 0, m_err_o 0, m_rdata_o 0 (when not valid), spurious_rsp_o 0.
  - s_req_o all 0.
- Request path latency: 0 cycles (combinational req→s_req and s_gnt→m_gnt).
- Error response: exactly 1 cycle after the grant cycle. Back-to-back ERR requests give back-to-back error responses.
- Full FIFO blocks grant even if a pop occurs in the same cycle; there is no rvalid→gnt combinational path.
- Reset mid-operation clears all outstanding entries. Later slave responses produce spurious_rsp_o pulses and are not forwarded.
- m_rdata_o is 0 whenever m_rvalid_o = 0.

## Structure
- Shared package cei_mochila_pkg holds:
  - the target id width function;
  - the ERR id encoding;
  - the ERR_RDATA default.
- addr_map_rule_t stays in addr_map_rule_pkg.
- Sub-module cei_id_fifo: synchronous FIFO parametrised on width and depth, with full/empty flags, last-pushed output, simultaneous push/pop, and synchronous active-high reset.
- The demux instantiates one cycle-free priority decoder as a function.

## Test plan
- Rules: 0:[0x1000,0x2000)→slave 1; 1:[0x1800,0x3000)→slave 2.
  - Read 0x1800 routes to slave 1 (priority).
  - Read 0x2000 routes to slave 2 (end exclusive).
  - Read 0x3000 gives an error response 1 cycle after grant with rdata 0xBADACCE5 and err 1.
- Four back-to-back reads to slave 1 (gnt always 1, rvalid withheld), then a fifth: no grant until the first rvalid; each rdata is returned in order.
- Read to slave 1 outstanding, then a request to slave 2: s_req_o[2] stays 0 until slave 1 rvalid. The grant follows in the same cycle the FIFO empties.
- Rule with idx = NSLAVE+2 → treated as ERR. Three consecutive ERR requests → three consecutive error responses.
- Assert rst_i for 1 cycle with 2 transactions outstanding, then drive s_rvalid_i[1]: m_rvalid_o stays 0, spurious_rsp_o pulses once, and the count reads 0.
- Simultaneous push and pop at count 2 → count stays 2 and ordering is preserved.
